// File: rtl/ucie_ctl_sb_rx_buffered_if.sv
// ucie_ctl_sb_rx_buffered_if
//   Bundles the sideband receiver's beat input, FIFO drain handshake, credit
//   return and status outputs.
//   master : the link/consumer side (drives beats and ready, observes status)
//   slave  : the receiver itself
//   Signals:
//     i_pl_cfg_vld / i_received_data[N-1:0]  beat stream, LSB-first
//     i_rdi_ready                            consumer accepts FIFO head
//     o_cfg_crd                              credit-return pulse
//     o_sb_*_error, o_sb_unsupported_message error pulses
//     o_sb_overflow                          sticky credit violation
//     o_valid_pl_sb / o_rdi_pl_sb_decode / o_rdi_pl_adv_cap_value  FIFO head
//     o_fifo_level                           FIFO occupancy
interface ucie_ctl_sb_rx_buffered_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4
);
  logic                     i_pl_cfg_vld;
  logic [N-1:0]             i_received_data;
  logic                     i_rdi_ready;
  logic                     o_cfg_crd;
  logic                     o_sb_src_error;
  logic                     o_sb_dst_error;
  logic                     o_sb_opcode_error;
  logic                     o_sb_unsupported_message;
  logic                     o_sb_parity_error;
  logic                     o_sb_overflow;
  logic                     o_valid_pl_sb;
  logic [4:0]               o_rdi_pl_sb_decode;
  logic [31:0]              o_rdi_pl_adv_cap_value;
  logic [$clog2(DEPTH):0]   o_fifo_level;

  modport master (
    output i_pl_cfg_vld, i_received_data, i_rdi_ready,
    input  o_cfg_crd, o_sb_src_error, o_sb_dst_error, o_sb_opcode_error,
           o_sb_unsupported_message, o_sb_parity_error, o_sb_overflow,
           o_valid_pl_sb, o_rdi_pl_sb_decode, o_rdi_pl_adv_cap_value, o_fifo_level
  );

  modport slave (
    input  i_pl_cfg_vld, i_received_data, i_rdi_ready,
    output o_cfg_crd, o_sb_src_error, o_sb_dst_error, o_sb_opcode_error,
           o_sb_unsupported_message, o_sb_parity_error, o_sb_overflow,
           o_valid_pl_sb, o_rdi_pl_sb_decode, o_rdi_pl_adv_cap_value, o_fifo_level
  );
endinterface

// File: rtl/ucie_ctl_sb_rx_buffered.sv
// ucie_ctl_sb_rx_buffered
//   UCIe sideband receiver for the RDI path. Assembles N-bit beats into a
//   64-bit header plus optional 64-bit data word, checks parity/opcode/src/dst,
//   decodes link-management and AdvCap messages, queues good messages in a
//   DEPTH-entry FIFO and returns credits to the sender.
//   Ports:
//     i_clk  single rising-edge clock
//     i_rst  synchronous active-high reset
//     sb     ucie_ctl_sb_rx_buffered_if.slave (beats, drain handshake, status)
//   Optional feature macro: UCIE_SB_RX_PARITY_CHK_EN
//     defined   : CP/DP parity checked, o_sb_parity_error can pulse
//     undefined : parity bits ignored, o_sb_parity_error tied to 0
module ucie_ctl_sb_rx_buffered #(
  parameter int         N      = 32,
  parameter int         DEPTH  = 4,
  parameter logic [2:0] SRC_ID = 3'b001,
  parameter logic [2:0] DST_ID = 3'b101
) (
  input logic i_clk,
  input logic i_rst,
  ucie_ctl_sb_rx_buffered_if.slave sb
);
  localparam int BEATS = 64 / N;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [4:0] OP_NODATA = 5'b10010;
  localparam logic [4:0] OP_DATA   = 5'b11011;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_CHECK} state_t;

  typedef struct packed {
    logic [4:0]  decode;
    logic [31:0] adv_cap;
  } entry_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_cnt_q;
  logic [63:0]   hdr_q, data_q;
  logic          last_beat;
  logic [4:0]    beat_op;

  logic          hdr_we, data_we, chk_en;
  logic          is_data, par_err, op_err, src_err, dst_err;
  logic [2:0]    sub_idx;
  logic [4:0]    dec_c;
  logic          e_par, e_op, e_src, e_dst, e_uns, good_c;

  logic          par_err_q, op_err_q, src_err_q, dst_err_q, uns_err_q, good_q;
  logic [4:0]    dec_q;
  logic [31:0]   adv_q;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, pop, push, drop, ovf_evt, ovf_q;

  logic [7:0]    crd_pend_q;
  logic [1:0]    crd_inc;
  logic [8:0]    crd_sum;
  logic          crd_q;
  logic          unused_bits;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  // The opcode sits in beat 0, so on a single-beat header it comes straight
  // from the bus; otherwise it is already in hdr_q.
  assign beat_op   = (beat_cnt_q == '0) ? sb.i_received_data[4:0] : hdr_q[4:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_HDR;
    else       state_q <= state_d;
  end

  // CHECK behaves like HDR for incoming beats so a new message may start in
  // the same cycle the previous one is being checked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR, S_CHECK: begin
        state_d = S_HDR;
        if (sb.i_pl_cfg_vld && last_beat)
          state_d = (beat_op == OP_DATA) ? S_DATA : S_CHECK;
      end
      S_DATA: begin
        if (sb.i_pl_cfg_vld && last_beat) state_d = S_CHECK;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    hdr_we  = sb.i_pl_cfg_vld && (state_q != S_DATA);
    data_we = sb.i_pl_cfg_vld && (state_q == S_DATA);
    chk_en  = (state_q == S_CHECK);

    is_data = (hdr_q[4:0] == OP_DATA);
    op_err  = (hdr_q[4:0] != OP_NODATA) && !is_data;
    src_err = (hdr_q[31:29] != SRC_ID);
    dst_err = (hdr_q[58:56] != DST_ID);
`ifdef UCIE_SB_RX_PARITY_CHK_EN
    par_err = (hdr_q[62] != ^hdr_q[61:0]) ||
              (hdr_q[63] != (is_data ? ^data_q : 1'b0));
`else
    par_err = 1'b0;
`endif

    sub_idx = 3'd0;
    case (hdr_q[39:32])
      8'h01:   sub_idx = 3'd1;
      8'h04:   sub_idx = 3'd2;
      8'h08:   sub_idx = 3'd3;
      8'h09:   sub_idx = 3'd4;
      8'h0A:   sub_idx = 3'd5;
      8'h0B:   sub_idx = 3'd6;
      8'h0C:   sub_idx = 3'd7;
      default: sub_idx = 3'd0;
    endcase

    dec_c = 5'd0;
    if (hdr_q[21:14] == 8'h01 && sub_idx != 3'd0)
      dec_c = {2'b00, sub_idx};
    else if (hdr_q[21:14] == 8'h02 && sub_idx != 3'd0)
      dec_c = 5'd8 + {2'b00, sub_idx};
    else if (hdr_q[21:14] == 8'h03 && hdr_q[39:32] == 8'h00 && is_data)
      dec_c = 5'd16;

    // Priority chain: exactly one error reported per message.
    e_par  = par_err;
    e_op   = !par_err && op_err;
    e_src  = !par_err && !op_err && src_err;
    e_dst  = !par_err && !op_err && !src_err && dst_err;
    e_uns  = !par_err && !op_err && !src_err && !dst_err && (dec_c == 5'd0);
    good_c = !(e_par || e_op || e_src || e_dst || e_uns);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt_q <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
    end else if (sb.i_pl_cfg_vld) begin
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CW'(1);
      if (hdr_we)  hdr_q[int'(beat_cnt_q)*N +: N]  <= sb.i_received_data;
      if (data_we) data_q[int'(beat_cnt_q)*N +: N] <= sb.i_received_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_err_q <= 1'b0;
      op_err_q  <= 1'b0;
      src_err_q <= 1'b0;
      dst_err_q <= 1'b0;
      uns_err_q <= 1'b0;
      good_q    <= 1'b0;
      dec_q     <= '0;
      adv_q     <= '0;
    end else begin
      par_err_q <= chk_en && e_par;
      op_err_q  <= chk_en && e_op;
      src_err_q <= chk_en && e_src;
      dst_err_q <= chk_en && e_dst;
      uns_err_q <= chk_en && e_uns;
      good_q    <= chk_en && good_c;
      dec_q     <= dec_c;
      adv_q     <= (dec_c == 5'd16) ? data_q[31:0] : 32'd0;
    end
  end

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop     = !empty && sb.i_rdi_ready;
  // A full FIFO that pops this cycle still has room for the incoming push.
  assign push    = good_q && (!full || pop);
  assign ovf_evt = good_q && full && !pop;
  assign drop    = par_err_q || op_err_q || src_err_q || dst_err_q || uns_err_q;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= '{decode: dec_q, adv_cap: adv_q};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (ovf_evt) ovf_q <= 1'b1;
    end
  end

  // Pending credits drain one per cycle; a drop and a pop can both add one.
  assign crd_inc = 2'(drop) + 2'(pop);
  assign crd_sum = 9'(crd_pend_q) + 9'(crd_inc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crd_pend_q <= '0;
      crd_q      <= 1'b0;
    end else if (crd_sum != 9'd0) begin
      crd_pend_q <= 8'(crd_sum - 9'd1);
      crd_q      <= 1'b1;
    end else begin
      crd_q      <= 1'b0;
    end
  end

  assign sb.o_cfg_crd                = crd_q;
  assign sb.o_sb_parity_error        = par_err_q;
  assign sb.o_sb_opcode_error        = op_err_q;
  assign sb.o_sb_src_error           = src_err_q;
  assign sb.o_sb_dst_error           = dst_err_q;
  assign sb.o_sb_unsupported_message = uns_err_q;
  assign sb.o_sb_overflow            = ovf_q;
  assign sb.o_valid_pl_sb            = !empty;
  assign sb.o_rdi_pl_sb_decode       = empty ? 5'd0  : mem[rd_ptr_q].decode;
  assign sb.o_rdi_pl_adv_cap_value   = empty ? 32'd0 : mem[rd_ptr_q].adv_cap;
  assign sb.o_fifo_level             = level_q;

  // Reserved header bits and the upper data word carry no meaning here.
  assign unused_bits = ^{hdr_q, data_q};
endmodule
